// File: rtl/mem_map_pkg.sv
// -----------------------------------------------------------------------------
// mem_map_pkg
// Shared address map and timer state type for the data-side memory responder.
// Every address is a word-aligned byte address on the CPU data bus.
// -----------------------------------------------------------------------------
package mem_map_pkg;

  // Base of the memory-mapped I/O window. RAM sits at 0 and must stay below it.
  localparam logic [31:0] IO_BASE    = 32'h0001_0000;
  localparam logic [31:0] ADDR_LED   = IO_BASE + 32'h0000_0000;
  localparam logic [31:0] ADDR_SW    = IO_BASE + 32'h0000_0004;
  localparam logic [31:0] ADDR_CYCLE = IO_BASE + 32'h0000_0008;
  localparam logic [31:0] ADDR_TIMER = IO_BASE + 32'h0000_000C;
  localparam logic [31:0] ADDR_TSTAT = IO_BASE + 32'h0000_0010;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  // Clears the byte-offset bits so every access is treated as a whole word.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/io_timer.sv
// -----------------------------------------------------------------------------
// io_timer
// One-shot countdown timer with a sticky expired flag.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   load      in   strobe: load load_val into the counter this edge
//   load_val  in   new count; zero stops the timer without expiring
//   clear     in   strobe: clear the expired flag (an expiry on the same edge wins)
//   count     out  current count
//   expired   out  sticky flag, set on the edge the count runs from 1 to 0
// -----------------------------------------------------------------------------
module io_timer
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        clear,
  output logic [31:0] count,
  output logic        expired
);

  timer_state_t state_q, state_d;
  logic [31:0]  count_q, count_d;
  logic         expire;
  logic         expired_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: every output of this block is given a default first; without that a
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          count_d = load_val;
          state_d = (load_val != '0) ? RUN : IDLE;
        end
      end
      RUN: begin
        // A write during RUN restarts or cancels; it never counts as an expiry.
        if (load) begin
          count_d = load_val;
          state_d = (load_val != '0) ? RUN : IDLE;
        end else if (count_q == 32'd1) begin
          count_d = '0;
          state_d = IDLE;
          expire  = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
    endcase
  end

  // Set has priority over clear so a status write cannot swallow an expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expired_q <= 1'b0;
    end else if (expire) begin
      expired_q <= 1'b1;
    end else if (clear) begin
      expired_q <= 1'b0;
    end
  end

  assign count   = count_q;
  assign expired = expired_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-side responder for the single-cycle CPU. Decodes the CPU byte address,
// serves a word-addressed RAM plus a small I/O window (LEDs, switches, cycle
// counter, countdown timer) and returns read data combinationally.
//
// Parameters
//   RAM_WORDS  data RAM depth in 32-bit words (power of two, <= 16384)
//   SW_W       switch input width
//   LED_W      LED register width
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   MemWrite       in   write strobe, sampled at the rising edge
//   ALUResult      in   byte address; bits [1:0] ignored
//   WriteData      in   store data
//   ReadData       out  load data, combinational from ALUResult
//   sw             in   asynchronous board switches
//   leds           out  LED register
//   timer_expired  out  sticky timer-expired flag
//   bus_err        out  sticky flag, set by a write to an unmapped address
// -----------------------------------------------------------------------------
module dmem_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int SW_W      = 8,
  parameter int LED_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  leds,
  output logic              timer_expired,
  output logic              bus_err
);

  localparam int AW = $clog2(RAM_WORDS);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0] addr;
  logic        hit_ram, hit_led, hit_sw, hit_cycle, hit_timer, hit_tstat;
  logic        hit_any;

  assign addr      = word_addr(ALUResult);
  assign hit_ram   = (addr[31:AW+2] == '0);
  assign hit_led   = (addr == ADDR_LED);
  assign hit_sw    = (addr == ADDR_SW);
  assign hit_cycle = (addr == ADDR_CYCLE);
  assign hit_timer = (addr == ADDR_TIMER);
  assign hit_tstat = (addr == ADDR_TSTAT);
  // Read-only registers count as mapped: writing them is ignored, not an error.
  assign hit_any   = hit_ram | hit_led | hit_sw | hit_cycle | hit_timer | hit_tstat;

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [31:0] mem [RAM_WORDS];

  // NOTE: the RAM array has no reset so it maps onto plain memory macros or
  // LUT RAM; software must initialise any word before reading it.
  always_ff @(posedge clk) begin
    if (MemWrite && hit_ram) begin
      mem[addr[AW+1:2]] <= WriteData;
    end
  end

  // ---------------------------------------------------------------------------
  // LED, switch synchroniser, cycle counter, bus error
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0] leds_q;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [31:0]      cycle_q;
  logic             bus_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cycle_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      cycle_q   <= cycle_q + 32'd1;
      if (MemWrite && hit_led) begin
        leds_q <= WriteData[LED_W-1:0];
      end
      if (MemWrite && !hit_any) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Countdown timer
  // ---------------------------------------------------------------------------
  logic [31:0] timer_count;
  logic        timer_exp;

  io_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (MemWrite && hit_timer),
    .load_val (WriteData),
    .clear    (MemWrite && hit_tstat),
    .count    (timer_count),
    .expired  (timer_exp)
  );

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    ReadData = '0;
    if (hit_ram) begin
      ReadData = mem[addr[AW+1:2]];
    end else if (hit_led) begin
      ReadData = 32'(leds_q);
    end else if (hit_sw) begin
      ReadData = 32'(sw_sync_q);
    end else if (hit_cycle) begin
      ReadData = cycle_q;
    end else if (hit_timer) begin
      ReadData = timer_count;
    end else if (hit_tstat) begin
      ReadData = {31'b0, timer_exp};
    end
  end

  assign leds          = leds_q;
  assign timer_expired = timer_exp;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed stimulus with literal expectations, plus a reference model that
// tracks the memory map in terms of elapsed cycles and timer deadlines and is
// compared against the DUT outputs on every falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int RAM_WORDS = 1024;
  localparam int SW_W      = 8;
  localparam int LED_W     = 8;

  localparam logic [31:0] A_LED = 32'h0001_0000;
  localparam logic [31:0] A_SW  = 32'h0001_0004;
  localparam logic [31:0] A_CYC = 32'h0001_0008;
  localparam logic [31:0] A_TMR = 32'h0001_000C;
  localparam logic [31:0] A_TST = 32'h0001_0010;

  logic              clk       = 1'b0;
  logic              reset     = 1'b0;
  logic              MemWrite  = 1'b0;
  logic [31:0]       ALUResult = '0;
  logic [31:0]       WriteData = '0;
  logic [SW_W-1:0]   sw        = '0;
  logic [31:0]       ReadData;
  logic [LED_W-1:0]  leds;
  logic              timer_expired;
  logic              bus_err;

  dmem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .SW_W      (SW_W),
    .LED_W     (LED_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWrite      (MemWrite),
    .ALUResult     (ALUResult),
    .WriteData     (WriteData),
    .ReadData      (ReadData),
    .sw            (sw),
    .leds          (leds),
    .timer_expired (timer_expired),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0]     m_ram [RAM_WORDS];
  bit              m_ok  [RAM_WORDS];
  logic [LED_W-1:0] m_led;
  logic [31:0]     m_cyc;
  longint          m_now;        // edges since reset release
  longint          m_deadline;   // edge number at which the running timer expires
  bit              m_run;
  bit              m_exp;
  bit              m_berr;
  logic [SW_W-1:0] m_swq [$];    // switch samples, newest first

  always @(posedge clk or negedge reset) begin : model_update
    logic [31:0] a;
    bit          expiring;
    if (!reset) begin
      m_led      = '0;
      m_cyc      = '0;
      m_now      = 0;
      m_deadline = 0;
      m_run      = 0;
      m_exp      = 0;
      m_berr     = 0;
      m_swq.delete();
    end else begin
      a = ALUResult & ~32'h3;
      m_now++;
      m_cyc = m_cyc + 32'd1;
      m_swq.push_front(sw);
      if (m_swq.size() > 2) void'(m_swq.pop_back());
      expiring = m_run && (m_now == m_deadline);
      if (expiring) m_run = 0;
      if (MemWrite) begin
        if (a < RAM_WORDS * 4) begin
          m_ram[int'(a >> 2)] = WriteData;
          m_ok[int'(a >> 2)]  = 1;
        end else if (a == A_LED) begin
          m_led = WriteData[LED_W-1:0];
        end else if (a == A_TMR) begin
          if (WriteData != 0) begin
            m_run      = 1;
            m_deadline = m_now + longint'(WriteData);
          end else begin
            m_run = 0;
          end
        end else if (a == A_TST) begin
          m_exp = 0;
        end else if (a != A_SW && a != A_CYC) begin
          m_berr = 1;
        end
      end
      if (expiring && !(MemWrite && a == A_TMR)) m_exp = 1;
    end
  end

  // Returns 0 when the expected value is unknown (RAM word never written).
  function automatic bit m_read(input logic [31:0] addr, output logic [31:0] v);
    logic [31:0] a;
    a = addr & ~32'h3;
    v = '0;
    if (a < RAM_WORDS * 4) begin
      v = m_ram[int'(a >> 2)];
      return m_ok[int'(a >> 2)];
    end
    case (a)
      A_LED:   v = 32'(m_led);
      A_SW:    v = (m_swq.size() == 2) ? 32'(m_swq[1]) : 32'd0;
      A_CYC:   v = m_cyc;
      A_TMR:   v = m_run ? 32'(m_deadline - m_now) : 32'd0;
      A_TST:   v = {31'b0, m_exp};
      default: v = '0;
    endcase
    return 1;
  endfunction

  always @(negedge clk) begin : compare
    logic [31:0] v;
    check("model_leds", 32'(leds), 32'(m_led));
    check("model_timer_expired", 32'(timer_expired), 32'(m_exp));
    check("model_bus_err", 32'(bus_err), 32'(m_berr));
    if (m_read(ALUResult, v)) check("model_ReadData", ReadData, v);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all entered and left 1 ns after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ALUResult = a;
    WriteData = d;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    ALUResult = a;
    MemWrite  = 1'b0;
    #1;
    check(name, ReadData, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_expired", 32'(timer_expired), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    rd("rst_timer", A_TMR, 32'h0);
    rd("rst_cycle", A_CYC, 32'h0);
    rd("rst_tstat", A_TST, 32'h0);
    rd("rst_sw", A_SW, 32'h0);
    reset = 1'b1;
    tick();

    // RAM store/load, byte offset ignored
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_load_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_load_13", 32'h0000_0013, 32'hDEAD_BEEF);
    check("ram_bus_err", 32'(bus_err), 32'h0);
    wr(32'h0000_0FFC, 32'h1234_5678);
    wr(32'h0000_0000, 32'hCAFE_0001);
    rd("ram_last_word", 32'h0000_0FFC, 32'h1234_5678);
    rd("ram_word0", 32'h0000_0002, 32'hCAFE_0001);

    // LED register
    wr(A_LED, 32'h0000_00A5);
    check("led_out", 32'(leds), 32'h0000_00A5);
    rd("led_read", A_LED, 32'h0000_00A5);
    wr(A_LED, 32'hFFFF_FF5A);
    rd("led_upper_zero", A_LED, 32'h0000_005A);

    // Switch synchroniser: change lands before edge 0
    sw = 8'h3C;
    rd("sw_before_e0", A_SW, 32'h0);
    tick();
    rd("sw_at_e1", A_SW, 32'h0);
    tick();
    rd("sw_at_e2", A_SW, 32'h0000_003C);
    tick();
    rd("sw_at_e3", A_SW, 32'h0000_003C);

    // Timer countdown of 5 with status writes around expiry
    wr(A_TMR, 32'd5);
    for (int i = 5; i >= 2; i--) begin
      rd($sformatf("tmr5_count_%0d", i), A_TMR, 32'(i));
      check("tmr5_not_expired", 32'(timer_expired), 32'h0);
      tick();
    end
    rd("tmr5_count_1", A_TMR, 32'd1);
    wr(A_TST, 32'h0);                       // same edge as expiry: set wins
    check("tmr5_expired_set_wins", 32'(timer_expired), 32'h1);
    rd("tmr5_tstat", A_TST, 32'h1);
    rd("tmr5_count_0", A_TMR, 32'h0);
    wr(A_TST, 32'h0);
    check("tmr5_tstat_clear", 32'(timer_expired), 32'h0);

    // Load of 1 expires after the next edge
    wr(A_TMR, 32'd1);
    rd("tmr1_count", A_TMR, 32'd1);
    check("tmr1_pre", 32'(timer_expired), 32'h0);
    tick();
    check("tmr1_expired", 32'(timer_expired), 32'h1);
    wr(A_TST, 32'hFFFF_FFFF);
    check("tmr1_cleared", 32'(timer_expired), 32'h0);

    // Cancel: load 10, write 0 three cycles later
    wr(A_TMR, 32'd10);
    tick();
    tick();
    wr(A_TMR, 32'd0);
    rd("tmr_cancel_count", A_TMR, 32'h0);
    repeat (12) tick();
    check("tmr_cancel_no_expiry", 32'(timer_expired), 32'h0);
    rd("tmr_cancel_still_0", A_TMR, 32'h0);

    // Restart during RUN
    wr(A_TMR, 32'd10);
    tick();
    wr(A_TMR, 32'd3);
    rd("tmr_restart_3", A_TMR, 32'd3);
    tick();
    rd("tmr_restart_2", A_TMR, 32'd2);
    tick();
    rd("tmr_restart_1", A_TMR, 32'd1);
    check("tmr_restart_pre", 32'(timer_expired), 32'h0);
    tick();
    check("tmr_restart_expired", 32'(timer_expired), 32'h1);

    // Writes to read-only registers are silently ignored
    wr(A_SW, 32'hFFFF_FFFF);
    wr(A_CYC, 32'h0);
    check("ro_write_no_err", 32'(bus_err), 32'h0);
    rd("ro_sw_unchanged", A_SW, 32'h0000_003C);

    // Unmapped accesses
    rd("unmapped_past_ram", 32'h0000_1000, 32'h0);
    wr(32'h0002_0000, 32'h1234);
    check("unmapped_bus_err", 32'(bus_err), 32'h1);
    rd("unmapped_read", 32'h0002_0000, 32'h0);
    rd("unmapped_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    check("unmapped_led_kept", 32'(leds), 32'h0000_005A);
    tick();
    check("bus_err_sticky", 32'(bus_err), 32'h1);

    // Asynchronous reset mid-count
    wr(A_TMR, 32'd20);
    tick();
    ALUResult = A_TMR;
    #2;
    reset = 1'b0;
    #1;
    check("areset_leds", 32'(leds), 32'h0);
    check("areset_expired", 32'(timer_expired), 32'h0);
    check("areset_bus_err", 32'(bus_err), 32'h0);
    check("areset_timer", ReadData, 32'h0);
    tick();
    rd("areset_cycle", A_CYC, 32'h0);
    reset = 1'b1;
    tick();
    rd("release_cycle_1", A_CYC, 32'd1);
    rd("release_timer_idle", A_TMR, 32'h0);
    tick();
    rd("release_cycle_2", A_CYC, 32'd2);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side responder for the single-cycle CPU's memory bus. It takes the CPU's `MemWrite`/`ALUResult`/`WriteData` request and returns `ReadData` in the same cycle. It contains a word-addressed data RAM and a small memory-mapped I/O region: LED register, synchronized switch input, free-running cycle counter and a one-shot countdown timer. It sits beside the instruction memory at top level, with the CPU as the only initiator.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; power of two, ≤ 16384.
- `SW_W`, 8: switch input width.
- `LED_W`, 8: LED output width.

- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `MemWrite` in 1: write strobe from CPU, sampled at rising edge.
- `ALUResult` in 32: byte address from CPU.
- `WriteData` in 32: store data from CPU.
- `ReadData` out 32: load data to CPU, combinational from address.
- `sw` in SW_W: asynchronous board switches.
- `leds` out LED_W: LED register contents.
- `timer_expired` out 1: sticky timer-expired flag.
- `bus_err` out 1: sticky flag, set by any write to an unmapped address.

## Operation
- Address decode uses `ALUResult[31:0]`. `ALUResult[1:0]` is ignored, so all accesses are whole words.
- Memory map:
  - RAM: 0x0000_0000 up to RAM_WORDS*4−1.
  - LED at 0x0001_0000: RW, low LED_W bits; upper read bits are 0.
  - SW at 0x0001_0004: RO, synchronized value, zero-extended.
  - CYCLE at 0x0001_0008: RO.
  - TIMER at 0x0001_000C: W loads the count; R returns the current count.
  - TSTAT at 0x0001_0010: R bit0 = expired; any W clears it.
- Unmapped read returns 0x0000_0000. Unmapped write has no effect except setting `bus_err`. Writes to RO registers are ignored and do not set `bus_err`.
- RAM: combinational read of `mem[ALUResult[log2(RAM_WORDS)+1:2]]`; write on the rising edge when `MemWrite`=1. RAM contents are not reset.
- SW: 2-flop synchronizer, reset value 0.
- CYCLE: increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- Timer FSM:
  - IDLE: count holds. A TIMER write of N≠0 loads N and moves to RUN. A TIMER write of 0 stays IDLE.
  - RUN: count decrements by 1 per cycle. When count=1 it becomes 0, `expired` is set and the FSM returns to IDLE. A TIMER write of N≠0 reloads N and stays RUN (restart). A TIMER write of 0 clears count and goes to IDLE without expiring.
- `expired` is set in the same cycle as the RUN→IDLE transition. If a TSTAT write and an expiry occur in the same cycle, the set wins.
- `bus_err` is cleared only by reset.

## Timing
- Reset values: `leds`=0, CYCLE=0, timer count=0, FSM=IDLE, `timer_expired`=0, `bus_err`=0, SW sync flops=0. `ReadData` follows the address combinationally, so it is also valid during reset (RAM contents unknown).
- Read latency: 0 cycles. Every read returns the registered value as of the current cycle.
- A write takes effect at the rising edge. A load from the same address in the next cycle returns the new value.
- SW latency: a `sw` change is visible on reads 2 rising edges later.
- Timer: loading N at edge t puts the FSM in RUN with count=N. `timer_expired` rises after edge t+N. Loading N=1 gives expiry after edge t+1.
- A CYCLE read at edge k returns the value before that edge's increment, i.e. k since reset release.
- Reset asserted mid-count returns the FSM to IDLE immediately (asynchronously). Reset asserted during a write cycle drops that write for registers; a RAM write is undefined in that cycle.

## Structure
- Package `mem_map_pkg`:
  - address constants: `ADDR_LED`, `ADDR_SW`, `ADDR_CYCLE`, `ADDR_TIMER`, `ADDR_TSTAT`, `IO_BASE`;
  - typedef `timer_state_t` {IDLE, RUN}.
- Sub-module `io_timer`: countdown FSM, count register and sticky expired flag. Interface: load strobe, load value, clear strobe, count out, expired out.
- Top-level `dmem_responder` holds decode, RAM, LED/SW/CYCLE registers and the read mux.

## Test plan
- Reset release, then store 0xDEAD_BEEF at 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 → both loads return 0xDEAD_BEEF; `bus_err`=0.
- Write 0x0000_00A5 to 0x0001_0000 → `leds`=0xA5 after that edge; a load from 0x0001_0000 returns 0x0000_00A5.
- Drive `sw`=0x3C at edge 0 → a SW read returns 0x0 at edge 1 and 0x0000_003C from edge 2 on.
- Write 5 to TIMER at edge t → TIMER reads 5,4,3,2,1 on the following cycles; `timer_expired`=1 after edge t+5. A TSTAT write at t+5 still leaves it at 1; a TSTAT write at t+6 clears it to 0.
- Write 10 to TIMER, then write 0 three cycles later → count=0, FSM IDLE, `timer_expired` stays 0. A restart write of 3 during RUN expires 3 cycles after the restart.
- Write to 0x0002_0000 → `bus_err`=1 and RAM/registers unchanged; a read there returns 0. Pulse `reset` low mid-count → all outputs return to reset values immediately.
